// File: rtl/csa_accumulator_if.sv
// Operand-in / result-out handshake bundle for csa_accumulator.
interface csa_accumulator_if #(
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 24,
  parameter int CNT_WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  in_data;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_data;
  logic [CNT_WIDTH-1:0] out_count;
  logic                 out_ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_ovf
  );
endinterface

// File: rtl/csa_accumulator.sv
// Carry-save accumulator: one 3:2 row per operand, one CPA resolve per group.
// Optional CSA_ACC_SATURATE_EN clamps an overflowing result to all ones.
module csa_fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);
endmodule

module csa_accumulator #(
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 24,
  parameter int CNT_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  csa_accumulator_if.slave   bus
);
  typedef enum logic [1:0] {ACCUM, RESOLVE, HOLD} state_t;

  typedef struct packed {
    logic [ACC_WIDTH-1:0] data;
    logic [CNT_WIDTH-1:0] count;
    logic                 ovf;
  } res_t;

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] sum_q, sum_d, carry_q, carry_d;
  logic [ACC_WIDTH-1:0] x_ext, fa_s, fa_maj;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  res_t                 res_q, res_d;
  logic [ACC_WIDTH:0]   resolved;
  logic                 accept, deliver, res_ovf;

  assign x_ext = {{(ACC_WIDTH-IN_WIDTH){1'b0}}, bus.in_data};

  // One compressor row; carry_q[0] and the zero-extended x bits reduce these to half adders.
  csa_fa_cell u_row [ACC_WIDTH-1:0] (
    .a  (sum_q),
    .b  (carry_q),
    .c  (x_ext),
    .s  (fa_s),
    .co (fa_maj)
  );

  assign resolved = {1'b0, sum_q} + {1'b0, carry_q};
  assign res_ovf  = ovf_q | resolved[ACC_WIDTH];
  assign accept   = bus.in_valid & in_ready_q;
  assign deliver  = out_valid_q & bus.out_ready;

  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          sum_d   = fa_s;
          carry_d = {fa_maj[ACC_WIDTH-2:0], 1'b0};
          // A majority out of the top bit is a dropped 2^ACC_WIDTH; remember it.
          ovf_d   = ovf_q | fa_maj[ACC_WIDTH-1];
          cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);
          if (bus.in_last) begin
            state_d    = RESOLVE;
            in_ready_d = 1'b0;
          end
        end
      end
      RESOLVE: begin
`ifdef CSA_ACC_SATURATE_EN
        res_d.data = res_ovf ? '1 : resolved[ACC_WIDTH-1:0];
`else
        res_d.data = resolved[ACC_WIDTH-1:0];
`endif
        res_d.ovf   = res_ovf;
        res_d.count = cnt_q;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (deliver) begin
          sum_d       = '0;
          carry_d     = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ACCUM;
        end
      end
      default: begin
        state_d     = ACCUM;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      sum_q       <= '0;
      carry_q     <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = res_q.data;
  assign bus.out_count = res_q.count;
  assign bus.out_ovf   = res_q.ovf;
endmodule
